// File: rtl/mips_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mips_mmio_timer
// Purpose  : MMIO responder for the data-memory bus. Implements a small
//            register-mapped down-counting timer with a prescaler. It returns
//            registered read data, flags unmapped or misaligned accesses, and
//            drives a level interrupt toward the core.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                    in   1   core clock
//   rst_n                  in   1   synchronous reset, active-low
//   data_mmio_wr_addr_val  in   1   write strobe for the MMIO region
//   data_mmio_wr_addr      in   32  write byte offset within the MMIO region
//   mmio_wr_data           in   32  write data
//   data_mmio_rd_addr_val  in   1   read strobe for the MMIO region
//   data_mmio_rd_addr      in   32  read byte offset within the MMIO region
//   mmio_rd_data           out  32  registered read data
//   mmio_rd_data_val       out  1   one-cycle pulse, mmio_rd_data valid
//   mmio_wr_resp_error     out  1   one-cycle pulse, previous write was bad
//   mmio_rd_resp_error     out  1   one-cycle pulse, previous read was bad
//   timer_irq              out  1   level interrupt (EXPIRED & IRQ_EN)
// ----------------------------------------------------------------------------
// Register map (byte offsets, word aligned)
//   0x00 CTRL     bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   0x04 LOAD     reload value
//   0x08 COUNT    live count; write loads it and clears the prescaler counter
//   0x0C STATUS   bit0 EXPIRED, write-1-to-clear
//   0x10 PRESCALE low PRESCALE_W bits
//   0x14 CYCLES   free-running cycle counter, read-only
//                 (only when MIPS_MMIO_CYCLE_CNT_EN is defined)
// Optional feature macro: MIPS_MMIO_CYCLE_CNT_EN
// ============================================================================
module mips_mmio_timer #(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [31:0] RESET_LOAD = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_mmio_wr_addr_val,
    input  logic [31:0] data_mmio_wr_addr,
    input  logic [31:0] mmio_wr_data,
    input  logic        data_mmio_rd_addr_val,
    input  logic [31:0] data_mmio_rd_addr,
    output logic [31:0] mmio_rd_data,
    output logic        mmio_rd_data_val,
    output logic        mmio_wr_resp_error,
    output logic        mmio_rd_resp_error,
    output logic        timer_irq
);

    localparam logic [31:0] c_OFF_CTRL     = 32'h0000_0000;
    localparam logic [31:0] c_OFF_LOAD     = 32'h0000_0004;
    localparam logic [31:0] c_OFF_COUNT    = 32'h0000_0008;
    localparam logic [31:0] c_OFF_STATUS   = 32'h0000_000C;
    localparam logic [31:0] c_OFF_PRESCALE = 32'h0000_0010;
`ifdef MIPS_MMIO_CYCLE_CNT_EN
    localparam logic [31:0] c_OFF_CYCLES   = 32'h0000_0014;
    localparam logic [31:0] c_ADDR_BOUND   = 32'h0000_0018;
`else
    localparam logic [31:0] c_ADDR_BOUND   = 32'h0000_0014;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]            r_ctrl_q,     w_ctrl_d;
    logic [31:0]           r_load_q,     w_load_d;
    logic [31:0]           r_count_q,    w_count_d;
    logic                  r_expired_q,  w_expired_d;
    logic [PRESCALE_W-1:0] r_prescale_q, w_prescale_d;
    logic [PRESCALE_W-1:0] r_pcnt_q,     w_pcnt_d;
    logic [31:0]           r_rd_data_q,  w_rd_data_d;
    logic                  r_rd_val_q,   w_rd_val_d;
    logic                  r_rd_err_q,   w_rd_err_d;
    logic                  r_wr_err_q,   w_wr_err_d;
`ifdef MIPS_MMIO_CYCLE_CNT_EN
    logic [31:0]           r_cycles_q,   w_cycles_d;
`endif

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic w_wr_bad, w_rd_bad, w_wr_ok;
    logic w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status, w_wr_prescale;

    assign w_wr_bad = (data_mmio_wr_addr >= c_ADDR_BOUND) || (data_mmio_wr_addr[1:0] != 2'b00);
    assign w_rd_bad = (data_mmio_rd_addr >= c_ADDR_BOUND) || (data_mmio_rd_addr[1:0] != 2'b00);
    assign w_wr_ok  = data_mmio_wr_addr_val & ~w_wr_bad;

    assign w_wr_ctrl     = w_wr_ok && (data_mmio_wr_addr == c_OFF_CTRL);
    assign w_wr_load     = w_wr_ok && (data_mmio_wr_addr == c_OFF_LOAD);
    assign w_wr_count    = w_wr_ok && (data_mmio_wr_addr == c_OFF_COUNT);
    assign w_wr_status   = w_wr_ok && (data_mmio_wr_addr == c_OFF_STATUS);
    assign w_wr_prescale = w_wr_ok && (data_mmio_wr_addr == c_OFF_PRESCALE);

    // ------------------------------------------------------------------------
    // Read mux: always sources the pre-write register values, so a read and a
    // write to the same register in one cycle returns the old contents.
    // Unmapped or misaligned offsets fall through to zero.
    // ------------------------------------------------------------------------
    logic [31:0] w_rd_value;

    always_comb begin
        w_rd_value = '0;
        case (data_mmio_rd_addr)
            c_OFF_CTRL:     w_rd_value[2:0] = r_ctrl_q;
            c_OFF_LOAD:     w_rd_value = r_load_q;
            c_OFF_COUNT:    w_rd_value = r_count_q;
            c_OFF_STATUS:   w_rd_value[0] = r_expired_q;
            c_OFF_PRESCALE: w_rd_value[PRESCALE_W-1:0] = r_prescale_q;
`ifdef MIPS_MMIO_CYCLE_CNT_EN
            c_OFF_CYCLES:   w_rd_value = r_cycles_q;
`endif
            default:        w_rd_value = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Timer next-state
    // ------------------------------------------------------------------------
    logic w_run, w_tick, w_tick_eff, w_expire;

    always_comb begin
        // A CTRL write that clears EN stops the timer in the same cycle, so any
        // tick that would have fired at this edge is dropped.
        w_run    = r_ctrl_q[0] & ~(w_wr_ctrl & ~mmio_wr_data[0]);
        w_tick   = 1'b0;
        w_pcnt_d = r_pcnt_q;
        if (w_run) begin
            if (r_pcnt_q == r_prescale_q) begin
                w_tick   = 1'b1;
                w_pcnt_d = '0;
            end else begin
                w_pcnt_d = r_pcnt_q + PRESCALE_W'(1);
            end
        end

        // A COUNT write overrides the whole tick (count, expiry and EN clear).
        w_tick_eff = w_tick & ~w_wr_count;
        w_expire   = 1'b0;
        w_ctrl_d   = r_ctrl_q;
        w_count_d  = r_count_q;
        if (w_tick_eff) begin
            if (r_count_q != 32'd0) begin
                w_count_d = r_count_q - 32'd1;
            end else begin
                w_expire = 1'b1;
                if (r_ctrl_q[1]) begin
                    w_count_d = r_load_q;
                end else begin
                    w_ctrl_d[0] = 1'b0;
                end
            end
        end

        // Register writes take priority over the timer's own updates.
        if (w_wr_ctrl) begin
            w_ctrl_d = mmio_wr_data[2:0];
        end
        if (w_wr_count) begin
            w_count_d = mmio_wr_data;
            w_pcnt_d  = '0;
        end
        w_load_d     = w_wr_load ? mmio_wr_data : r_load_q;
        w_prescale_d = w_wr_prescale ? mmio_wr_data[PRESCALE_W-1:0] : r_prescale_q;

        // New expiry wins over a simultaneous write-1-to-clear.
        w_expired_d = (r_expired_q & ~(w_wr_status & mmio_wr_data[0])) | w_expire;

        // Bus responses.
        w_rd_val_d  = data_mmio_rd_addr_val;
        w_rd_err_d  = data_mmio_rd_addr_val & w_rd_bad;
        w_rd_data_d = data_mmio_rd_addr_val ? w_rd_value : r_rd_data_q;
        w_wr_err_d  = data_mmio_wr_addr_val & w_wr_bad;
    end

`ifdef MIPS_MMIO_CYCLE_CNT_EN
    assign w_cycles_d = r_cycles_q + 32'd1;
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl_q     <= '0;
            r_load_q     <= RESET_LOAD;
            r_count_q    <= RESET_LOAD;
            r_expired_q  <= 1'b0;
            r_prescale_q <= '0;
            r_pcnt_q     <= '0;
            r_rd_data_q  <= '0;
            r_rd_val_q   <= 1'b0;
            r_rd_err_q   <= 1'b0;
            r_wr_err_q   <= 1'b0;
`ifdef MIPS_MMIO_CYCLE_CNT_EN
            r_cycles_q   <= '0;
`endif
        end else begin
            r_ctrl_q     <= w_ctrl_d;
            r_load_q     <= w_load_d;
            r_count_q    <= w_count_d;
            r_expired_q  <= w_expired_d;
            r_prescale_q <= w_prescale_d;
            r_pcnt_q     <= w_pcnt_d;
            r_rd_data_q  <= w_rd_data_d;
            r_rd_val_q   <= w_rd_val_d;
            r_rd_err_q   <= w_rd_err_d;
            r_wr_err_q   <= w_wr_err_d;
`ifdef MIPS_MMIO_CYCLE_CNT_EN
            r_cycles_q   <= w_cycles_d;
`endif
        end
    end

    assign mmio_rd_data       = r_rd_data_q;
    assign mmio_rd_data_val   = r_rd_val_q;
    assign mmio_rd_resp_error = r_rd_err_q;
    assign mmio_wr_resp_error = r_wr_err_q;
    assign timer_irq          = r_expired_q & r_ctrl_q[2];

endmodule

`default_nettype wire

// File: tb/tb_mips_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mmio_timer
// Purpose  : Self-checking bench for mips_mmio_timer. Directed scenarios
//            followed by random bus traffic, all checked each cycle against a
//            behavioural model of the timer's register-level rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mmio_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_mmio_wr_addr_val = 1'b0;
    logic [31:0] data_mmio_wr_addr = '0;
    logic [31:0] mmio_wr_data = '0;
    logic        data_mmio_rd_addr_val = 1'b0;
    logic [31:0] data_mmio_rd_addr = '0;
    logic [31:0] mmio_rd_data;
    logic        mmio_rd_data_val;
    logic        mmio_wr_resp_error;
    logic        mmio_rd_resp_error;
    logic        timer_irq;

    always #5 clk = ~clk;

    mips_mmio_timer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .data_mmio_wr_addr_val (data_mmio_wr_addr_val),
        .data_mmio_wr_addr     (data_mmio_wr_addr),
        .mmio_wr_data          (mmio_wr_data),
        .data_mmio_rd_addr_val (data_mmio_rd_addr_val),
        .data_mmio_rd_addr     (data_mmio_rd_addr),
        .mmio_rd_data          (mmio_rd_data),
        .mmio_rd_data_val      (mmio_rd_data_val),
        .mmio_wr_resp_error    (mmio_wr_resp_error),
        .mmio_rd_resp_error    (mmio_rd_resp_error),
        .timer_irq             (timer_irq)
    );

`ifdef MIPS_MMIO_CYCLE_CNT_EN
    localparam int unsigned c_BOUND = 32'h18;
`else
    localparam int unsigned c_BOUND = 32'h14;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- behavioural model state ----------------
    int unsigned m_ctrl, m_load, m_count, m_status, m_prescale, m_pcnt, m_cycles;
    int unsigned m_rdd;
    bit          m_rdv, m_rderr, m_wrerr;

    int unsigned offs [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20, 32'h6};
    int unsigned exp_auto [5] = '{3, 2, 1, 0, 3};
    int unsigned exp_pre  [7] = '{5, 5, 5, 4, 4, 4, 3};

    function automatic bit m_bad(input int unsigned a);
        return (a >= c_BOUND) || (a % 4 != 0);
    endfunction

    function automatic int unsigned m_read(input int unsigned a);
        if (m_bad(a)) return 0;
        case (a)
            32'h0:  return m_ctrl;
            32'h4:  return m_load;
            32'h8:  return m_count;
            32'hC:  return m_status;
            32'h10: return m_prescale;
            default: return m_cycles;
        endcase
    endfunction

    task automatic m_reset();
        m_ctrl = 0; m_load = 32'hFFFF; m_count = 32'hFFFF; m_status = 0;
        m_prescale = 0; m_pcnt = 0; m_cycles = 0;
        m_rdd = 0; m_rdv = 0; m_rderr = 0; m_wrerr = 0;
    endtask

    // One clock edge worth of timer behaviour.
    task automatic m_step(input bit wv, input int unsigned wa, input int unsigned wd,
                          input bit rv, input int unsigned ra);
        bit wok, run, tick, stop_wr, cnt_wr, expire;
        int unsigned n_ctrl, n_count, n_pcnt;
        m_rdv   = rv;
        m_rderr = rv && m_bad(ra);
        if (rv) m_rdd = m_read(ra);
        m_wrerr = wv && m_bad(wa);
        wok     = wv && !m_bad(wa);
        stop_wr = wok && wa == 0 && (wd % 2 == 0);
        cnt_wr  = wok && wa == 8;
        run     = (m_ctrl % 2 == 1) && !stop_wr;
        tick    = run && (m_pcnt == m_prescale);
        n_pcnt  = !run ? m_pcnt : (tick ? 0 : (m_pcnt + 1) % 65536);
        n_ctrl  = m_ctrl;
        n_count = m_count;
        expire  = 0;
        if (tick && !cnt_wr) begin
            if (m_count > 0) n_count = m_count - 1;
            else begin
                expire = 1;
                if ((m_ctrl / 2) % 2 == 1) n_count = m_load;
                else n_ctrl = m_ctrl - 1;
            end
        end
        if (wok) begin
            case (wa)
                32'h0:  n_ctrl = wd % 8;
                32'h4:  m_load = wd;
                32'h8:  begin n_count = wd; n_pcnt = 0; end
                32'hC:  if (wd % 2 == 1) m_status = 0;
                32'h10: m_prescale = wd % 65536;
                default: ;
            endcase
        end
        if (expire) m_status = 1;
        m_ctrl   = n_ctrl;
        m_count  = n_count;
        m_pcnt   = n_pcnt;
        m_cycles = m_cycles + 1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("rd_val",  32'(mmio_rd_data_val),   32'(m_rdv));
        check("rd_err",  32'(mmio_rd_resp_error), 32'(m_rderr));
        check("wr_err",  32'(mmio_wr_resp_error), 32'(m_wrerr));
        check("rd_data", mmio_rd_data,            m_rdd);
        check("irq",     32'(timer_irq),          32'(m_status == 1 && (m_ctrl / 4) % 2 == 1));
    endtask

    task automatic do_cycle(input bit wv, input int unsigned wa, input int unsigned wd,
                            input bit rv, input int unsigned ra);
        data_mmio_wr_addr_val = wv;
        data_mmio_wr_addr     = wa;
        mmio_wr_data          = wd;
        data_mmio_rd_addr_val = rv;
        data_mmio_rd_addr     = ra;
        m_step(wv, wa, wd, rv, ra);
        @(posedge clk);
        #1;
        data_mmio_wr_addr_val = 1'b0;
        data_mmio_rd_addr_val = 1'b0;
        check_all();
    endtask

    task automatic wr(input int unsigned a, input int unsigned d);
        do_cycle(1, a, d, 0, 0);
    endtask

    task automatic rd(input int unsigned a);
        do_cycle(0, 0, 0, 1, a);
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input bit rv);
        rst_n                 = 1'b0;
        data_mmio_rd_addr_val = rv;
        data_mmio_rd_addr     = 32'h8;
        m_reset();
        @(posedge clk);
        #1;
        rst_n                 = 1'b1;
        data_mmio_rd_addr_val = 1'b0;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v1;
        int unsigned a, d;
        bit wv, rv;

        // Reset state and first read of LOAD.
        do_reset(0);
        check("reset_irq", 32'(timer_irq), 32'h0);
        rd(32'h4);
        check("load_reset", mmio_rd_data, 32'h0000_FFFF);
        check("load_val", 32'(mmio_rd_data_val), 32'h1);

        // Auto-reload countdown, prescale 0.
        wr(32'h4, 3); wr(32'h8, 3); wr(32'h10, 0); wr(32'h0, 7);
        for (int i = 0; i < 5; i++) begin
            rd(32'h8);
            check("auto_count", mmio_rd_data, exp_auto[i]);
        end
        check("auto_irq", 32'(timer_irq), 32'h1);
        wr(32'h0, 0);

        // One-shot expiry clears EN; W1C drops the interrupt.
        wr(32'hC, 1); wr(32'h8, 1); wr(32'h0, 5);
        idle(); idle();
        rd(32'h0);
        check("oneshot_ctrl", mmio_rd_data, 32'h4);
        rd(32'h8);
        check("oneshot_count", mmio_rd_data, 32'h0);
        check("oneshot_irq", 32'(timer_irq), 32'h1);
        wr(32'hC, 1);
        check("w1c_irq", 32'(timer_irq), 32'h0);

        // Prescale 2: one decrement every third cycle.
        wr(32'h10, 2); wr(32'h8, 5); wr(32'h0, 1);
        for (int i = 0; i < 7; i++) begin
            rd(32'h8);
            check("presc_count", mmio_rd_data, exp_pre[i]);
        end

        // W1C in the same cycle as an expiry: set wins.
        wr(32'h0, 0); wr(32'hC, 1); wr(32'h10, 0); wr(32'h8, 0); wr(32'h4, 5);
        wr(32'h0, 7);
        wr(32'hC, 1);
        rd(32'hC);
        check("w1c_race", mmio_rd_data, 32'h1);
        check("w1c_race_irq", 32'(timer_irq), 32'h1);
        wr(32'h0, 0);

        // Bad read and bad write together.
        do_cycle(1, 32'h6, 32'hDEAD_BEEF, 1, 32'h20);
        check("bad_rd_err", 32'(mmio_rd_resp_error), 32'h1);
        check("bad_wr_err", 32'(mmio_wr_resp_error), 32'h1);
        check("bad_rd_data", mmio_rd_data, 32'h0);
        idle();
        check("bad_rd_err_gone", 32'(mmio_rd_resp_error), 32'h0);
        rd(32'h4);
        check("bad_no_change", mmio_rd_data, 32'h5);

`ifdef MIPS_MMIO_CYCLE_CNT_EN
        rd(32'h14);
        v1 = mmio_rd_data;
        idle(); idle(); idle(); idle();
        rd(32'h14);
        check("cycles_diff", mmio_rd_data - v1, 32'h5);
        wr(32'h14, 32'h1234);
        check("cycles_wr_ok", 32'(mmio_wr_resp_error), 32'h0);
`else
        do_cycle(1, 32'h14, 32'h1, 1, 32'h14);
        check("off14_rd_err", 32'(mmio_rd_resp_error), 32'h1);
        check("off14_wr_err", 32'(mmio_wr_resp_error), 32'h1);
        v1 = '0;
`endif

        // Reset mid-count with a read pending.
        wr(32'h0, 1); idle(); idle();
        do_reset(1);
        check("rst_drop_val", 32'(mmio_rd_data_val), 32'h0);
        rd(32'h8);
        check("rst_count", mmio_rd_data, 32'h0000_FFFF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wv = ($urandom_range(0, 2) == 0);
            a  = offs[$urandom_range(0, 7)];
            case (a)
                32'h0:  d = $urandom_range(0, 7);
                32'h4:  d = $urandom_range(0, 6);
                32'h8:  d = $urandom_range(0, 6);
                32'hC:  d = $urandom_range(0, 1);
                32'h10: d = $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            rv = ($urandom_range(0, 1) == 1);
            do_cycle(wv, a, d, rv, offs[$urandom_range(0, 7)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
